// File: rtl/sort_avalon_pp_pkg.sv
// sort_avalon_pp_pkg: shared bank state type and helpers for the ping-pong
// Avalon-ST packet sorter.
package sort_avalon_pp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } bank_state_t;

  localparam int unsigned KEY_MAX_W = 64;

  function automatic int unsigned cnt_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Keys are zero-extended to a common width so any word/key geometry compares unsigned.
  function automatic logic [KEY_MAX_W-1:0] key_of(input logic [KEY_MAX_W-1:0] word,
                                                  input int unsigned          lsb,
                                                  input int unsigned          width);
    logic [KEY_MAX_W-1:0] mask;
    mask = (width >= KEY_MAX_W) ? '1 : ((KEY_MAX_W'(1) << width) - KEY_MAX_W'(1));
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/sort_avalon_pp_bank.sv
// sort_avalon_pp_bank: one packet buffer with an in-place odd-even transposition sort.
// The o_count port exists only when SORT_AVALON_PP_ERR_EN is defined.
module sort_avalon_pp_bank
  import sort_avalon_pp_pkg::*;
#(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 16,
  parameter int unsigned KEY_LSB     = 0,
  parameter int unsigned KEY_WIDTH   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_desc,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_rd,
  output bank_state_t       o_state,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_sop,
  output logic              o_eop
`ifdef SORT_AVALON_PP_ERR_EN
  ,
  output logic [$clog2(MAX_PKT_LEN+1)-1:0] o_count
`endif
);

  localparam int unsigned CW = cnt_width(MAX_PKT_LEN);
  localparam int unsigned IW = $clog2(MAX_PKT_LEN);

  bank_state_t          r_state;
  logic [DWIDTH-1:0]    r_mem  [MAX_PKT_LEN];
  logic [DWIDTH-1:0]    w_next [MAX_PKT_LEN];
  logic [KEY_MAX_W-1:0] w_key  [MAX_PKT_LEN];
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        r_pass;
  logic [CW-1:0]        r_idx;
  logic                 r_desc;

  always_comb begin
    for (int unsigned i = 0; i < MAX_PKT_LEN; i++) begin
      w_key[i] = key_of(KEY_MAX_W'(r_mem[i]), KEY_LSB, KEY_WIDTH);
    end
  end

  // One pass per cycle; pairs in a pass are disjoint so all swaps read r_mem.
  always_comb begin
    for (int unsigned i = 0; i < MAX_PKT_LEN; i++) begin
      w_next[i] = r_mem[i];
    end
    for (int unsigned i = 0; i + 1 < MAX_PKT_LEN; i++) begin
      if ((i[0] == r_pass[0]) && (CW'(i + 1) < r_count)) begin
        if (r_desc ? (w_key[i] < w_key[i+1]) : (w_key[i] > w_key[i+1])) begin
          w_next[i]   = r_mem[i+1];
          w_next[i+1] = r_mem[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_count <= '0;
      r_pass  <= '0;
      r_idx   <= '0;
      r_desc  <= 1'b0;
      for (int unsigned i = 0; i < MAX_PKT_LEN; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        EMPTY, FILL: begin
          r_pass <= '0;
          if (i_wr) begin
            if (i_sop) begin
              r_mem[0] <= i_data;
              r_count  <= CW'(1);
              r_desc   <= i_desc;
              r_state  <= i_eop ? SORT : FILL;
            end else if (r_state == FILL) begin
              if (r_count < CW'(MAX_PKT_LEN)) begin
                r_mem[IW'(r_count)] <= i_data;
                r_count             <= r_count + 1'b1;
              end
              if (i_eop) begin
                r_state <= SORT;
              end
            end
          end
        end
        SORT: begin
          r_mem <= w_next;
          if (r_pass == r_count - 1'b1) begin
            r_state <= DRAIN;
            r_idx   <= '0;
          end else begin
            r_pass <= r_pass + 1'b1;
          end
        end
        DRAIN: begin
          if (i_rd) begin
            if (r_idx == r_count - 1'b1) begin
              r_state <= EMPTY;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_data  = r_mem[IW'(r_idx)];
  assign o_sop   = (r_idx == '0);
  assign o_eop   = (r_idx == r_count - 1'b1);
`ifdef SORT_AVALON_PP_ERR_EN
  assign o_count = r_count;
`endif

endmodule

// File: rtl/sort_avalon_pp.sv
// sort_avalon_pp: Avalon-ST packet sorter with two ping-pong banks.
// Define SORT_AVALON_PP_ERR_EN to add the pkt_err_o / drop_cnt_o error reporting ports.
module sort_avalon_pp
  import sort_avalon_pp_pkg::*;
#(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 16,
  parameter int unsigned KEY_LSB     = 0,
  parameter int unsigned KEY_WIDTH   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sort_desc_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_valid_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  input  logic              src_ready_i
`ifdef SORT_AVALON_PP_ERR_EN
  ,
  output logic              pkt_err_o,
  output logic [15:0]       drop_cnt_o
`endif
);

  bank_state_t       w_state [2];
  logic [DWIDTH-1:0] w_data  [2];
  logic              w_sop   [2];
  logic              w_eop   [2];
  bank_state_t       w_wr_state;
  logic              r_live;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic              w_snk_xfer;
  logic              w_src_xfer;
  logic              w_close;

`ifdef SORT_AVALON_PP_ERR_EN
  localparam int unsigned CW = cnt_width(MAX_PKT_LEN);
  logic [CW-1:0] w_count [2];
  logic          w_orphan;
  logic          w_restart;
  logic          w_trunc;
  logic          r_pkt_err;
  logic [15:0]   r_drop_cnt;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sort_avalon_pp_bank #(
      .DWIDTH      (DWIDTH),
      .MAX_PKT_LEN (MAX_PKT_LEN),
      .KEY_LSB     (KEY_LSB),
      .KEY_WIDTH   (KEY_WIDTH)
    ) u_bank (
      .i_clk   (clk_i),
      .i_rst_n (rst_n_i),
      .i_wr    (w_snk_xfer && (r_wr_ptr == 1'(b))),
      .i_sop   (snk_startofpacket_i),
      .i_eop   (snk_endofpacket_i),
      .i_desc  (sort_desc_i),
      .i_data  (snk_data_i),
      .i_rd    (w_src_xfer && (r_rd_ptr == 1'(b))),
      .o_state (w_state[b]),
      .o_data  (w_data[b]),
      .o_sop   (w_sop[b]),
      .o_eop   (w_eop[b])
`ifdef SORT_AVALON_PP_ERR_EN
      ,
      .o_count (w_count[b])
`endif
    );
  end

  assign w_wr_state  = w_state[r_wr_ptr];
  assign snk_ready_o = r_live && ((w_wr_state == EMPTY) || (w_wr_state == FILL));
  assign w_snk_xfer  = snk_valid_i && snk_ready_o;
  // An orphan EOP in EMPTY is dropped and must not advance the write bank.
  assign w_close     = w_snk_xfer && snk_endofpacket_i &&
                       (snk_startofpacket_i || (w_wr_state == FILL));

  assign src_valid_o         = (w_state[r_rd_ptr] == DRAIN);
  assign w_src_xfer          = src_valid_o && src_ready_i;
  assign src_data_o          = src_valid_o ? w_data[r_rd_ptr] : '0;
  assign src_startofpacket_o = src_valid_o && w_sop[r_rd_ptr];
  assign src_endofpacket_o   = src_valid_o && w_eop[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_live   <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_close) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_src_xfer && src_endofpacket_o) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

`ifdef SORT_AVALON_PP_ERR_EN
  assign w_orphan  = w_snk_xfer && (w_wr_state == EMPTY) && !snk_startofpacket_i;
  assign w_restart = w_snk_xfer && (w_wr_state == FILL) && snk_startofpacket_i;
  assign w_trunc   = w_snk_xfer && (w_wr_state == FILL) && !snk_startofpacket_i &&
                     (w_count[r_wr_ptr] == CW'(MAX_PKT_LEN));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pkt_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_pkt_err <= w_orphan || w_restart || w_trunc;
      if ((w_orphan || w_trunc) && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign pkt_err_o  = r_pkt_err;
  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_sort_avalon_pp.sv
// tb_sort_avalon_pp: directed self-checking bench for the ping-pong packet sorter
// (key in the upper nibble, tag in the lower nibble of each 8-bit word).
`timescale 1ns/1ps
module tb_sort_avalon_pp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sort_desc;
  logic [7:0] snk_data;
  logic       snk_valid;
  logic       snk_sop;
  logic       snk_eop;
  logic       snk_ready_o;
  logic [7:0] src_data_o;
  logic       src_valid_o;
  logic       src_sop_o;
  logic       src_eop_o;
  logic       src_ready;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  logic [7:0]  tx       [32];
  logic [7:0]  got_data [32];
  logic        got_sop  [32];
  logic        got_eop  [32];
  int unsigned got_cyc  [32];
  int unsigned got_n;
  int unsigned xfer_cyc;

`ifdef SORT_AVALON_PP_ERR_EN
  logic        pkt_err;
  logic [15:0] drop_cnt;
  int unsigned err_hi = 0;
  always @(posedge clk) if (pkt_err === 1'b1) err_hi <= err_hi + 1;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort_avalon_pp #(
    .DWIDTH      (8),
    .MAX_PKT_LEN (16),
    .KEY_LSB     (4),
    .KEY_WIDTH   (4)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .sort_desc_i         (sort_desc),
    .snk_data_i          (snk_data),
    .snk_valid_i         (snk_valid),
    .snk_startofpacket_i (snk_sop),
    .snk_endofpacket_i   (snk_eop),
    .snk_ready_o         (snk_ready_o),
    .src_data_o          (src_data_o),
    .src_valid_o         (src_valid_o),
    .src_startofpacket_o (src_sop_o),
    .src_endofpacket_o   (src_eop_o),
    .src_ready_i         (src_ready)
`ifdef SORT_AVALON_PP_ERR_EN
    ,
    .pkt_err_o           (pkt_err),
    .drop_cnt_o          (drop_cnt)
`endif
  );

  task automatic drive_word(input logic [7:0] d, input logic sop, input logic eop, input logic desc);
    int unsigned n;
    n = 0;
    snk_data = d; snk_sop = sop; snk_eop = eop; sort_desc = desc; snk_valid = 1'b1;
    while (snk_ready_o !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL sink_ready_timeout: ready=%b required 1", snk_ready_o);
    end
    xfer_cyc = cyc;
    @(posedge clk); #1;
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
  endtask

  task automatic send_pkt(input int unsigned len, input logic desc);
    for (int unsigned i = 0; i < len; i++) begin
      drive_word(tx[i], (i == 0), (i == len - 1), desc);
    end
  endtask

  task automatic collect(input int unsigned n, input logic toggle, input int unsigned budget);
    got_n = 0;
    for (int unsigned k = 0; k < budget && got_n < n; k++) begin
      src_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (src_valid_o === 1'b1 && src_ready === 1'b1) begin
        got_data[got_n] = src_data_o;
        got_sop[got_n]  = src_sop_o;
        got_eop[got_n]  = src_eop_o;
        got_cyc[got_n]  = cyc;
        got_n++;
      end
      @(posedge clk); #1;
    end
    src_ready = 1'b0;
    if (got_n < n) begin
      checks++; errors++;
      $display("FAIL collect_timeout: beats=%0d required %0d", got_n, n);
    end
  endtask

  task automatic wait_valid();
    int unsigned n;
    n = 0;
    while (src_valid_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (src_valid_o !== 1'b1) begin
      errors++; $display("FAIL wait_valid: valid=%b required 1", src_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL reset_snk_ready: got %b required 0", snk_ready_o); end
    checks++;
    if ({src_valid_o, src_sop_o, src_eop_o} !== 3'b000) begin
      errors++; $display("FAIL reset_src_ctrl: got %b required 000", {src_valid_o, src_sop_o, src_eop_o});
    end
    checks++;
    if (src_data_o !== 8'h00) begin errors++; $display("FAIL reset_src_data: got %h required 00", src_data_o); end
    rst_n = 1'b1;
    checks++;
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b required 0", snk_ready_o); end
    @(posedge clk); #1;
    checks++;
    if (snk_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %b required 1", snk_ready_o); end
`ifdef SORT_AVALON_PP_ERR_EN
    checks++;
    if (drop_cnt !== 16'd0 || pkt_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: drop=%0d err=%b required 0 0", drop_cnt, pkt_err);
    end
`endif
  endtask

  task automatic test_ascending();
    logic [7:0] exp_d [4];
    exp_d = '{8'h1D, 8'h3B, 8'h5A, 8'h9C};
    tx[0] = 8'h5A; tx[1] = 8'h3B; tx[2] = 8'h9C; tx[3] = 8'h1D;
    fork
      send_pkt(4, 1'b0);
      collect(4, 1'b0, 100);
    join
    for (int unsigned i = 0; i < 4; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL asc_data[%0d]: got %h required %h", i, got_data[i], exp_d[i]); end
    end
    checks++;
    if ({got_sop[0], got_sop[1], got_sop[2], got_sop[3]} !== 4'b1000) begin
      errors++; $display("FAIL asc_sop: got %b%b%b%b required 1000", got_sop[0], got_sop[1], got_sop[2], got_sop[3]);
    end
    checks++;
    if ({got_eop[0], got_eop[1], got_eop[2], got_eop[3]} !== 4'b0001) begin
      errors++; $display("FAIL asc_eop: got %b%b%b%b required 0001", got_eop[0], got_eop[1], got_eop[2], got_eop[3]);
    end
    checks++;
    if (got_cyc[0] - xfer_cyc !== 32'd5) begin
      errors++; $display("FAIL asc_latency: got %0d required 5", got_cyc[0] - xfer_cyc);
    end
  endtask

  task automatic test_desc_ties();
    logic [7:0] exp_d [3];
    exp_d = '{8'h7C, 8'h2A, 8'h2B};
    tx[0] = 8'h2A; tx[1] = 8'h2B; tx[2] = 8'h7C;
    fork
      send_pkt(3, 1'b1);
      collect(3, 1'b0, 100);
    join
    for (int unsigned i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL desc_data[%0d]: got %h required %h", i, got_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [12];
    exp_d = '{8'h13, 8'h21, 8'h40, 8'h82,
              8'h95, 8'h67, 8'h36, 8'h14,
              8'h09, 8'h7A, 8'h7B, 8'hF8};
    fork
      begin
        tx[0] = 8'h40; tx[1] = 8'h21; tx[2] = 8'h82; tx[3] = 8'h13;
        send_pkt(4, 1'b0);
        checks++;
        if (snk_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_one_busy: got %b required 1", snk_ready_o); end
        tx[0] = 8'h14; tx[1] = 8'h95; tx[2] = 8'h36; tx[3] = 8'h67;
        send_pkt(4, 1'b1);
        checks++;
        if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_both_busy: got %b required 0", snk_ready_o); end
        tx[0] = 8'hF8; tx[1] = 8'h09; tx[2] = 8'h7A; tx[3] = 8'h7B;
        send_pkt(4, 1'b0);
      end
      collect(12, 1'b1, 400);
    join
    for (int unsigned i = 0; i < 12; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_sop[i] !== (i % 4 == 0) || got_eop[i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_beat[%0d]: got %h sop=%b eop=%b required %h sop=%b eop=%b",
                 i, got_data[i], got_sop[i], got_eop[i], exp_d[i], (i % 4 == 0), (i % 4 == 3));
      end
    end
  endtask

  task automatic test_backpressure_trunc();
    logic [7:0]  held;
    int unsigned bad;
    logic [7:0]  exp_v;
`ifdef SORT_AVALON_PP_ERR_EN
    int unsigned err_base;
    err_base = err_hi;
`endif
    for (int unsigned i = 0; i < 16; i++) tx[i] = {4'(15 - i), 4'(i)};
    tx[16] = 8'h00; tx[17] = 8'h01;
    src_ready = 1'b0;
    send_pkt(18, 1'b0);
    wait_valid();
    held = src_data_o;
    bad  = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (src_valid_o !== 1'b1 || src_data_o !== held) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold: unstable cycles %0d required 0", bad); end
    checks++;
    if (held !== 8'h0F) begin errors++; $display("FAIL bp_first: got %h required 0f", held); end
    collect(16, 1'b0, 100);
    for (int unsigned j = 0; j < 16; j++) begin
      exp_v = {4'(j), 4'(15 - j)};
      checks++;
      if (got_data[j] !== exp_v) begin errors++; $display("FAIL trunc_data[%0d]: got %h required %h", j, got_data[j], exp_v); end
    end
    checks++;
    if (got_eop[15] !== 1'b1) begin errors++; $display("FAIL trunc_eop: got %b required 1", got_eop[15]); end
    checks++;
    if (src_valid_o !== 1'b0) begin errors++; $display("FAIL trunc_extra_beat: valid=%b required 0", src_valid_o); end
`ifdef SORT_AVALON_PP_ERR_EN
    checks++;
    if (drop_cnt !== 16'd2) begin errors++; $display("FAIL trunc_drop_cnt: got %0d required 2", drop_cnt); end
    checks++;
    if (err_hi == err_base) begin errors++; $display("FAIL trunc_pkt_err: pulses %0d required >0", err_hi - err_base); end
`endif
  endtask

  task automatic test_framing();
    drive_word(8'h99, 1'b0, 1'b0, 1'b0);
    drive_word(8'h11, 1'b1, 1'b0, 1'b0);
    drive_word(8'h22, 1'b0, 1'b0, 1'b0);
    drive_word(8'h55, 1'b1, 1'b0, 1'b0);
    drive_word(8'h44, 1'b0, 1'b1, 1'b0);
    collect(2, 1'b0, 100);
    checks++;
    if (got_data[0] !== 8'h44 || got_data[1] !== 8'h55) begin
      errors++; $display("FAIL framing_data: got %h %h required 44 55", got_data[0], got_data[1]);
    end
    checks++;
    if ({got_sop[0], got_eop[1]} !== 2'b11) begin errors++; $display("FAIL framing_flags: got %b required 11", {got_sop[0], got_eop[1]}); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (src_valid_o !== 1'b0) begin errors++; $display("FAIL framing_extra: valid=%b required 0", src_valid_o); end
`ifdef SORT_AVALON_PP_ERR_EN
    checks++;
    if (drop_cnt !== 16'd3) begin errors++; $display("FAIL framing_drop_cnt: got %0d required 3", drop_cnt); end
`endif
  endtask

  task automatic test_single_and_reset();
    logic [7:0] exp_d [3];
    exp_d = '{8'h60, 8'h70, 8'h80};
    drive_word(8'h37, 1'b1, 1'b1, 1'b0);
    collect(1, 1'b0, 50);
    checks++;
    if (got_data[0] !== 8'h37 || got_sop[0] !== 1'b1 || got_eop[0] !== 1'b1) begin
      errors++; $display("FAIL single: got %h sop=%b eop=%b required 37 1 1", got_data[0], got_sop[0], got_eop[0]);
    end
    tx[0] = 8'h40; tx[1] = 8'h30; tx[2] = 8'h20; tx[3] = 8'h10;
    send_pkt(4, 1'b0);
    wait_valid();
    src_ready = 1'b1;
    @(posedge clk); #1;
    src_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({src_valid_o, src_sop_o, src_eop_o, snk_ready_o} !== 4'b0000 || src_data_o !== 8'h00) begin
      errors++; $display("FAIL midreset_outputs: got %b data %h required 0000 data 00",
                         {src_valid_o, src_sop_o, src_eop_o, snk_ready_o}, src_data_o);
    end
`ifdef SORT_AVALON_PP_ERR_EN
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL midreset_drop_cnt: got %0d required 0", drop_cnt); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (snk_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", snk_ready_o); end
    tx[0] = 8'h80; tx[1] = 8'h70; tx[2] = 8'h60;
    fork
      send_pkt(3, 1'b0);
      collect(3, 1'b0, 100);
    join
    for (int unsigned i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL post_reset_data[%0d]: got %h required %h", i, got_data[i], exp_d[i]); end
    end
    checks++;
    if (got_sop[0] !== 1'b1 || got_eop[2] !== 1'b1) begin
      errors++; $display("FAIL post_reset_flags: got %b%b required 11", got_sop[0], got_eop[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0; sort_desc = 1'b0; snk_data = '0; snk_valid = 1'b0;
    snk_sop = 1'b0; snk_eop = 1'b0; src_ready = 1'b0;
    test_reset();
    test_ascending();
    test_desc_ties();
    test_back_to_back();
    test_backpressure_trunc();
    test_framing();
    test_single_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
